// File: rtl/mem_pkg.sv
// Shared opcodes, FSM state encoding and opcode helpers for the load/store sequencer.
package mem_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  function automatic logic op_is_load(input logic [2:0] op);
    return (op <= OP_LW);
  endfunction

  // Every 3-bit code is defined today; a wider Op field would land in the default.
  function automatic logic op_known(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge, alignment check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  Op,
  input  logic [1:0]  ByteOff,
  input  logic [31:0] MemRData,
  input  logic [31:0] WrData,
  output logic [31:0] LoadOut,
  output logic [31:0] MergeOut,
  output logic        Misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (ByteOff)
      2'd0:    byte_sel = MemRData[7:0];
      2'd1:    byte_sel = MemRData[15:8];
      2'd2:    byte_sel = MemRData[23:16];
      default: byte_sel = MemRData[31:24];
    endcase
    half_sel = ByteOff[1] ? MemRData[31:16] : MemRData[15:0];
  end

  always_comb begin
    LoadOut  = '0;
    MergeOut = WrData;
    Misalign = 1'b0;
    case (Op)
      OP_LB:  LoadOut = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: LoadOut = {24'h0, byte_sel};
      OP_LH: begin
        LoadOut  = {{16{half_sel[15]}}, half_sel};
        Misalign = ByteOff[0];
      end
      OP_LHU: begin
        LoadOut  = {16'h0, half_sel};
        Misalign = ByteOff[0];
      end
      OP_LW: begin
        LoadOut  = MemRData;
        Misalign = |ByteOff;
      end
      OP_SB: begin
        MergeOut = MemRData;
        MergeOut[{ByteOff, 3'b000} +: 8] = WrData[7:0];
      end
      OP_SH: begin
        MergeOut = ByteOff[1] ? {WrData[15:0], MemRData[15:0]}
                              : {MemRData[31:16], WrData[15:0]};
        Misalign = ByteOff[0];
      end
      OP_SW:   Misalign = |ByteOff;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: stalls the pipeline, runs read / RMW / write on a
// handshaked word memory with per-phase ack timeout.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req,
  input  logic [2:0]        Op,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WrData,
  output logic              Stall,
  output logic              Done,
  output logic [31:0]       RdData,
  output logic              Misalign,
  output logic              BusErr,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  input  logic [31:0]       MemRData,
  input  logic              MemAck
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  logic              done_q, done_d, mis_q, mis_d, berr_q, berr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d, rdata_q, rdata_d;

  logic [2:0]  al_op;
  logic [1:0]  al_off;
  logic [31:0] load_w, merge_w;
  logic        al_mis, acked, expired, unused_addr;

  // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
  assign al_op  = (state_q == IDLE) ? Op : op_q;
  assign al_off = (state_q == IDLE) ? Addr[1:0] : off_q;

  mem_lane_align u_align (
    .Op       (al_op),
    .ByteOff  (al_off),
    .MemRData (MemRData),
    .WrData   (wdata_q),
    .LoadOut  (load_w),
    .MergeOut (merge_w),
    .Misalign (al_mis)
  );

  assign acked       = req_q & MemAck;
  assign expired     = (cnt_q == CNT_LAST);
  assign unused_addr = ^Addr[31:ADDR_W+2];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    berr_d   = berr_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (Req) begin
        op_d    = Op;
        off_d   = Addr[1:0];
        wdata_d = WrData;
        maddr_d = Addr[ADDR_W+1:2];
        cnt_d   = '0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        rdata_d = '0;
        if (!op_known(Op)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (al_mis) begin
          state_d = DONE;
          mis_d   = 1'b1;
          done_d  = 1'b1;
        end else if (Op == OP_SW) begin
          state_d  = WR;
          req_d    = 1'b1;
          we_d     = 1'b1;
          mwdata_d = WrData;
        end else begin
          state_d = RD;
          req_d   = 1'b1;
          we_d    = 1'b0;
        end
      end
      RD: if (acked) begin
        req_d = 1'b0;
        cnt_d = '0;
        if (op_is_load(op_q)) begin
          state_d = DONE;
          rdata_d = load_w;
          done_d  = 1'b1;
        end else begin
          state_d  = WR;
          mwdata_d = merge_w;
        end
      end else if (expired) begin
        state_d = DONE;
        req_d   = 1'b0;
        berr_d  = 1'b1;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      // Entering WR from an RMW read arrives with MemReq low: that is the gap cycle.
      WR: if (!req_q) begin
        req_d = 1'b1;
        we_d  = 1'b1;
      end else if (acked) begin
        state_d = DONE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b1;
      end else if (expired) begin
        state_d = DONE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        berr_d  = 1'b1;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
      done_q   <= done_d;
    end
  end

  assign Stall    = (state_q == IDLE) ? Req : (state_q == RD || state_q == WR);
  assign Done     = done_q;
  assign RdData   = rdata_q;
  assign Misalign = mis_q;
  assign BusErr   = berr_q;
  assign MemReq   = req_q;
  assign MemWe    = we_q;
  assign MemAddr  = maddr_q;
  assign MemWData = mwdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: behavioural word memory with programmable ack delay.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;

  logic              Clk, Rst_n, Req;
  logic [2:0]        Op;
  logic [31:0]       Addr, WrData;
  logic              Stall, Done, Misalign, BusErr, MemReq, MemWe, MemAck;
  logic [31:0]       RdData, MemWData, MemRData;
  logic [ADDR_W-1:0] MemAddr;

  typedef struct {
    logic [31:0] rd;
    bit          chk_rd;
    bit          mis;
    bit          berr;
    int          lat;
    int          nreq;
    logic [3:0]  widx;
    bit          chk_mem;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int          ack_dly;
  bit          ack_never, block_wr;
  int          n_chk, n_err;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Op(Op), .Addr(Addr), .WrData(WrData),
    .Stall(Stall), .Done(Done), .RdData(RdData), .Misalign(Misalign), .BusErr(BusErr),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] b, h;
    b = w >> (8 * off);
    h = w >> (16 * off[1]);
    case (op)
      OP_LB:   return {{24{b[7]}}, b[7:0]};
      OP_LBU:  return {24'h0, b[7:0]};
      OP_LH:   return {{16{h[15]}}, h[15:0]};
      OP_LHU:  return {16'h0, h[15:0]};
      OP_LW:   return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_mis(input logic [2:0] op, input logic [1:0] off);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return off[0];
    if (op == OP_LW || op == OP_SW) return (off != 2'b00);
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_store(input logic [2:0] op, input logic [1:0] off,
                                          input logic [31:0] w, input logic [31:0] wd);
    logic [31:0] m;
    case (op)
      OP_SB: begin
        m = 32'h0000_00FF << (8 * off);
        return (w & ~m) | ((wd & 32'h0000_00FF) << (8 * off));
      end
      OP_SH: begin
        m = 32'h0000_FFFF << (16 * off[1]);
        return (w & ~m) | ((wd & 32'h0000_FFFF) << (16 * off[1]));
      end
      default: return wd;
    endcase
  endfunction

  // Word memory: ack after ack_dly un-acked cycles of MemReq.
  initial begin
    int wcnt;
    wcnt     = 0;
    MemAck   = 1'b0;
    MemRData = 32'h0;
    forever begin
      @(negedge Clk);
      MemAck = 1'b0;
      if (Rst_n && MemReq && !ack_never && !(MemWe && block_wr)) begin
        if (wcnt >= ack_dly) begin
          MemAck   = 1'b1;
          MemRData = mem[MemAddr[3:0]];
          if (MemWe) mem[MemAddr[3:0]] = MemWData;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // exp_lat > 0: start from IDLE and check the Done cycle index (Req cycle = 1).
  task automatic do_access(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int exp_lat);
    exp_t e, g;
    int   cyc, rises;
    bit   seen, prev;
    e.widx    = addr[5:2];
    e.mis     = m_mis(op, addr[1:0]);
    e.berr    = ack_never && !e.mis;
    e.chk_rd  = op_is_load(op) && !e.mis && !ack_never;
    e.rd      = m_load(op, addr[1:0], ref_mem[e.widx]);
    e.nreq    = e.mis ? 0 : ((op == OP_SB || op == OP_SH) && !ack_never) ? 2 : 1;
    e.chk_mem = !e.mis && !ack_never && !op_is_load(op);
    e.lat     = exp_lat;
    if (e.chk_mem) ref_mem[e.widx] = m_store(op, addr[1:0], ref_mem[e.widx], wd);
    sb.push_back(e);
    if (exp_lat > 0) begin
      Req = 1'b0;
      @(negedge Clk);
    end
    Req = 1'b1; Op = op; Addr = addr; WrData = wd;
    cyc = 1; rises = 0; prev = MemReq; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge Clk);
      cyc++;
      if (MemReq && !prev) rises++;
      prev = MemReq;
      if (Done) seen = 1'b1;
      else chk("stall_busy", 32'(Stall), 32'd1);
    end
    Req = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    g = sb.pop_front();
    if (seen) begin
      chk("stall_done", 32'(Stall), 32'd0);
      chk("misalign", 32'(Misalign), 32'(g.mis));
      chk("buserr", 32'(BusErr), 32'(g.berr));
      if (g.chk_rd) chk("rddata", RdData, g.rd);
      if (g.lat > 0) chk("latency", 32'(cyc), 32'(g.lat));
      chk("memreq_count", 32'(rises), 32'(g.nreq));
      if (g.chk_mem) chk("mem_word", mem[g.widx], ref_mem[g.widx]);
    end
  endtask

  initial begin
    bit          seen5;
    logic [31:0] a;
    n_chk = 0; n_err = 0;
    Rst_n = 1'b0; Req = 1'b0; Op = 3'd0; Addr = 32'h0; WrData = 32'h0;
    ack_dly = 0; ack_never = 1'b0; block_wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h12F4_5678; ref_mem[0] = mem[0];
    mem[1] = 32'h1122_3344; ref_mem[1] = mem[1];
    mem[2] = 32'h0102_0304; ref_mem[2] = mem[2];
    repeat (3) @(negedge Clk);
    chk("rst_memreq", 32'(MemReq), 32'd0);
    chk("rst_memwe", 32'(MemWe), 32'd0);
    chk("rst_memaddr", 32'(MemAddr), 32'd0);
    chk("rst_memwdata", MemWData, 32'd0);
    chk("rst_rddata", RdData, 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_flags", 32'({Misalign, BusErr}), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Loads with 1-cycle ack
    do_access(OP_LB,  32'h0000_0002, 32'h0, 3);
    chk("lb_value", RdData, 32'hFFFF_FFF4);
    do_access(OP_LBU, 32'h0000_0002, 32'h0, 3);
    chk("lbu_value", RdData, 32'h0000_00F4);
    do_access(OP_LH,  32'h0000_0002, 32'h0, 3);
    do_access(OP_LHU, 32'h0000_0000, 32'h0, 3);
    do_access(OP_LB,  32'h0000_0003, 32'h0, 3);
    do_access(OP_LW,  32'h0000_0000, 32'h0, 3);

    // Read-modify-write stores
    do_access(OP_SB, 32'h0000_0005, 32'h0000_00AB, 5);
    chk("sb_word", mem[1], 32'h1122_AB44);
    do_access(OP_SH, 32'h0000_0006, 32'hFFFF_BEEF, 5);

    // Misaligned: no memory traffic
    do_access(OP_LH, 32'h0000_0001, 32'h0, 2);
    do_access(OP_LW, 32'h0000_0002, 32'h0, 2);
    do_access(OP_SH, 32'h0000_0003, 32'h1234, 2);
    do_access(OP_SW, 32'h0000_0001, 32'h1234, 2);

    // Timeout, then ack landing exactly on the limit cycle
    ack_never = 1'b1;
    do_access(OP_LW, 32'h0000_0010, 32'h0, TIMEOUT + 2);
    ack_never = 1'b0;
    ack_dly   = TIMEOUT - 1;
    do_access(OP_LW, 32'h0000_0010, 32'h0, TIMEOUT + 2);
    ack_dly   = 0;

    // Async reset while the SH write phase is waiting for ack
    block_wr = 1'b1;
    Req = 1'b0;
    @(negedge Clk);
    Req = 1'b1; Op = OP_SH; Addr = 32'h0000_0008; WrData = 32'h0000_BEEF;
    seen5 = 1'b0;
    for (int k = 0; k < 20 && !seen5; k++) begin
      @(negedge Clk);
      if (MemReq && MemWe) seen5 = 1'b1;
    end
    chk("sh_reached_wr", 32'(seen5), 32'd1);
    Req = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_memreq", 32'(MemReq), 32'd0);
    chk("arst_memwe", 32'(MemWe), 32'd0);
    chk("arst_memaddr", 32'(MemAddr), 32'd0);
    chk("arst_memwdata", MemWData, 32'd0);
    chk("arst_done", 32'(Done), 32'd0);
    chk("arst_stall", 32'(Stall), 32'd0);
    @(negedge Clk);
    block_wr = 1'b0;
    Rst_n = 1'b1;
    chk("sh_abort_mem", mem[2], 32'h0102_0304);
    @(negedge Clk);
    do_access(OP_SW, 32'h0000_0008, 32'hCAFE_F00D, 3);

    // Back-to-back LW, LW, SW with random ack delays
    for (int i = 0; i < 8; i++) begin
      ack_dly = $urandom_range(0, 3);
      a = 32'($urandom_range(0, 15)) << 2;
      do_access(OP_LW, a, 32'h0, 0);
      ack_dly = $urandom_range(0, 3);
      a = 32'($urandom_range(0, 15)) << 2;
      do_access(OP_LW, a, 32'h0, 0);
      ack_dly = $urandom_range(0, 3);
      a = 32'($urandom_range(0, 15)) << 2;
      do_access(OP_SW, a, $urandom, 0);
    end
    ack_dly = 0;
    repeat (2) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
